// File: rtl/cordic_arb_pkg.sv
// Shared types and helpers for the CORDIC request arbiter.
// Optional feature macro used by the arbiter: CORDIC_ARB_TAG_CHECK_EN.
package cordic_arb_pkg;

    // Widest requester ID (NREQ <= 8) and widest result field carried in a FIFO entry.
    localparam int unsigned MAX_IDW = 3;
    localparam int unsigned MAX_DW  = 32;

    // Smallest r such that 2**r >= v.
    function automatic int unsigned ceil_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // One stage of the tag delay line.
    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] id;
    } arb_tag_t;

    // One result FIFO entry; unused upper bits are zero.
    typedef struct packed {
        logic [MAX_IDW-1:0] id;
        logic [MAX_DW-1:0]  x;
        logic [MAX_DW-1:0]  y;
        logic [MAX_DW-1:0]  a;
    } arb_res_t;

endpackage

// File: rtl/cordic_arb_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// Head data reads as zero while empty so outputs are clean after reset.
module cordic_arb_fifo
    import cordic_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic                         rd_valid_o,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic [ceil_log2(DEPTH):0]    count_o
);

    localparam int unsigned PW = ceil_log2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_c, pop_c;

    // Next-state for pointers and occupancy; writes to a full FIFO are ignored.
    always_comb begin
        push_c   = wr_en_i && (count_q != CW'(DEPTH));
        pop_c    = rd_en_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q + PW'(push_c);
        rd_ptr_d = rd_ptr_q + PW'(pop_c);
        count_d  = count_q + CW'(push_c) - CW'(pop_c);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr_q] <= wr_data_i;
    end

    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = rd_valid_o ? mem[rd_ptr_q] : '0;
    assign count_o    = count_q;

endmodule

// File: rtl/cordic_req_arbiter.sv
// Round-robin front end sharing one pipelined CORDIC engine between NREQ requesters.
// Issued operations are tagged through a LATENCY-deep delay line and results land in a
// credit-protected FWFT FIFO. Define CORDIC_ARB_TAG_CHECK_EN to add the sticky
// tag/result misalignment checker; otherwise tag_err is tied low.
// OUT_BITS must not exceed cordic_arb_pkg::MAX_DW and NREQ must be 2..8.
module cordic_req_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned IN_BITS    = 16,
    parameter int unsigned OUT_BITS   = 16,
    parameter int unsigned LATENCY    = 28,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          nGrst,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*IN_BITS-1:0]       req_x,
    input  logic [NREQ*IN_BITS-1:0]       req_y,
    input  logic [NREQ*IN_BITS-1:0]       req_a,
    output logic                          cor_din_valid,
    output logic [IN_BITS-1:0]            cor_din_x,
    output logic [IN_BITS-1:0]            cor_din_y,
    output logic [IN_BITS-1:0]            cor_din_a,
    input  logic                          cor_dout_valid,
    input  logic [OUT_BITS-1:0]           cor_out_x,
    input  logic [OUT_BITS-1:0]           cor_out_y,
    input  logic [OUT_BITS-1:0]           cor_out_a,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ceil_log2(NREQ)-1:0]    res_id,
    output logic [OUT_BITS-1:0]           res_x,
    output logic [OUT_BITS-1:0]           res_y,
    output logic [OUT_BITS-1:0]           res_a,
    output logic                          tag_err
);

    localparam int unsigned IDW   = ceil_log2(NREQ);
    localparam int unsigned IDW1  = IDW + 1;
    localparam int unsigned CNTW  = ceil_log2(FIFO_DEPTH) + 1;
    localparam int unsigned CNTW1 = CNTW + 1;

    logic [IDW-1:0]     rr_q, rr_d;
    logic [IDW-1:0]     grant_id_c;
    logic [IDW1-1:0]    sum_c;
    logic [IDW-1:0]     idx_c;
    logic               found_c, credit_ok_c, grant_c;
    logic [CNTW-1:0]    inflight_q, inflight_d;
    logic [CNTW-1:0]    fcount;
    logic               din_valid_q, din_valid_d;
    logic [IN_BITS-1:0] din_x_q, din_x_d, din_y_q, din_y_d, din_a_q, din_a_d;
    logic [IDW-1:0]     din_id_q, din_id_d;
    arb_tag_t           tag_q [LATENCY];
    arb_tag_t           tag_out_c;
    logic               wr_en_c;
    arb_res_t           wr_entry_c, rd_entry;
    logic               unused_c;

    // Credit check and round-robin search starting at rr; no grant while in reset.
    always_comb begin
        credit_ok_c = ({1'b0, inflight_q} + {1'b0, fcount}) < CNTW1'(FIFO_DEPTH);
        found_c     = 1'b0;
        grant_id_c  = '0;
        sum_c       = '0;
        idx_c       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum_c = {1'b0, rr_q} + IDW1'(k);
            if (sum_c >= IDW1'(NREQ)) sum_c = sum_c - IDW1'(NREQ);
            idx_c = IDW'(sum_c);
            if (!found_c && req_valid[idx_c]) begin
                found_c    = 1'b1;
                grant_id_c = idx_c;
            end
        end
        grant_c   = found_c && credit_ok_c && nGrst;
        req_ready = grant_c ? (NREQ'(1) << grant_id_c) : '0;
    end

    // Tag-line head and FIFO write entry; only results with a live tag are stored.
    always_comb begin
        tag_out_c    = tag_q[LATENCY-1];
        wr_en_c      = cor_dout_valid && tag_out_c.valid;
        wr_entry_c   = '0;
        wr_entry_c.id = tag_out_c.id;
        wr_entry_c.x  = MAX_DW'(cor_out_x);
        wr_entry_c.y  = MAX_DW'(cor_out_y);
        wr_entry_c.a  = MAX_DW'(cor_out_a);
    end

    // Next-state for pointer, issue registers and in-flight credit counter.
    always_comb begin
        rr_d        = rr_q;
        din_valid_d = grant_c;
        din_x_d     = din_x_q;
        din_y_d     = din_y_q;
        din_a_d     = din_a_q;
        din_id_d    = din_id_q;
        if (grant_c) begin
            rr_d     = (grant_id_c == IDW'(NREQ - 1)) ? '0 : grant_id_c + IDW'(1);
            din_x_d  = req_x[grant_id_c*IN_BITS +: IN_BITS];
            din_y_d  = req_y[grant_id_c*IN_BITS +: IN_BITS];
            din_a_d  = req_a[grant_id_c*IN_BITS +: IN_BITS];
            din_id_d = grant_id_c;
        end
        inflight_d = inflight_q + CNTW'(grant_c) - CNTW'(wr_en_c);
    end

    // Arbiter, issue and credit registers.
    always_ff @(posedge clk) begin
        if (!nGrst) begin
            rr_q        <= '0;
            inflight_q  <= '0;
            din_valid_q <= 1'b0;
            din_x_q     <= '0;
            din_y_q     <= '0;
            din_a_q     <= '0;
            din_id_q    <= '0;
        end else begin
            rr_q        <= rr_d;
            inflight_q  <= inflight_d;
            din_valid_q <= din_valid_d;
            din_x_q     <= din_x_d;
            din_y_q     <= din_y_d;
            din_a_q     <= din_a_d;
            din_id_q    <= din_id_d;
        end
    end

    // Tag delay line, loaded alongside cor_din_valid so its head meets cor_dout_valid.
    always_ff @(posedge clk) begin
        if (!nGrst) begin
            for (int unsigned k = 0; k < LATENCY; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0].valid <= din_valid_q;
            tag_q[0].id    <= MAX_IDW'(din_id_q);
            for (int unsigned k = 1; k < LATENCY; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    cordic_arb_fifo #(
        .WIDTH ($bits(arb_res_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (nGrst),
        .wr_en_i    (wr_en_c),
        .wr_data_i  (wr_entry_c),
        .rd_en_i    (res_ready),
        .rd_valid_o (res_valid),
        .rd_data_o  (rd_entry),
        .count_o    (fcount)
    );

    assign cor_din_valid = din_valid_q;
    assign cor_din_x     = din_x_q;
    assign cor_din_y     = din_y_q;
    assign cor_din_a     = din_a_q;
    assign res_id        = rd_entry.id[IDW-1:0];
    assign res_x         = rd_entry.x[OUT_BITS-1:0];
    assign res_y         = rd_entry.y[OUT_BITS-1:0];
    assign res_a         = rd_entry.a[OUT_BITS-1:0];
    assign unused_c      = ^rd_entry;

`ifdef CORDIC_ARB_TAG_CHECK_EN
    logic tag_err_q, tag_err_d;

    // Any disagreement between engine strobe and tag valid latches the error.
    always_comb begin
        tag_err_d = tag_err_q | (cor_dout_valid ^ tag_out_c.valid);
    end

    // Sticky error register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!nGrst) tag_err_q <= 1'b0;
        else        tag_err_q <= tag_err_d;
    end

    assign tag_err = tag_err_q;
`else
    assign tag_err = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Directed bench for cordic_req_arbiter with a fixed-latency engine model
// (x+1, y passthrough, a inverted). Honours CORDIC_ARB_TAG_CHECK_EN.
module tb_cordic_req_arbiter;

    localparam int NREQ  = 4;
    localparam int IB    = 16;
    localparam int OB    = 16;
    localparam int LAT   = 28;
    localparam int DEPTH = 32;
`ifdef CORDIC_ARB_TAG_CHECK_EN
    localparam logic TAG_EXP = 1'b1;
`else
    localparam logic TAG_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              nGrst;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*IB-1:0] req_x, req_y, req_a;
    logic              cor_din_valid;
    logic [IB-1:0]     cor_din_x, cor_din_y, cor_din_a;
    logic              cor_dout_valid;
    logic [OB-1:0]     cor_out_x, cor_out_y, cor_out_a;
    logic              res_valid, res_ready;
    logic [1:0]        res_id;
    logic [OB-1:0]     res_x, res_y, res_a;
    logic              tag_err;
    logic              spur;

    int vecs = 0;
    int errs = 0;
    logic [1:0] exp_q [$];

    always #5 clk = ~clk;

    cordic_req_arbiter #(
        .NREQ(NREQ), .IN_BITS(IB), .OUT_BITS(OB), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .nGrst(nGrst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_a(req_a),
        .cor_din_valid(cor_din_valid), .cor_din_x(cor_din_x), .cor_din_y(cor_din_y), .cor_din_a(cor_din_a),
        .cor_dout_valid(cor_dout_valid), .cor_out_x(cor_out_x), .cor_out_y(cor_out_y), .cor_out_a(cor_out_a),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_x(res_x), .res_y(res_y), .res_a(res_a),
        .tag_err(tag_err)
    );

    // Engine model: fixed LAT-cycle pipeline that ignores reset.
    logic [LAT-1:0] eng_v;
    logic [IB-1:0]  eng_x [LAT];
    logic [IB-1:0]  eng_y [LAT];
    logic [IB-1:0]  eng_a [LAT];
    always @(posedge clk) begin
        eng_v <= {eng_v[LAT-2:0], (cor_din_valid === 1'b1)};
        eng_x[0] <= cor_din_x;
        eng_y[0] <= cor_din_y;
        eng_a[0] <= cor_din_a;
        for (int k = 1; k < LAT; k++) begin
            eng_x[k] <= eng_x[k-1];
            eng_y[k] <= eng_y[k-1];
            eng_a[k] <= eng_a[k-1];
        end
    end
    assign cor_dout_valid = eng_v[LAT-1] | spur;
    assign cor_out_x      = eng_x[LAT-1] + 16'd1;
    assign cor_out_y      = eng_y[LAT-1];
    assign cor_out_a      = eng_a[LAT-1] ^ 16'hFFFF;

    // Expected engine results for the default operand set of requester id.
    function automatic logic [15:0] exp_x(input logic [1:0] id);
        return 16'h1000 + 16'h0111 * {14'd0, id} + 16'h0001;
    endfunction
    function automatic logic [15:0] exp_y(input logic [1:0] id);
        return 16'h2000 + {14'd0, id};
    endfunction
    function automatic logic [15:0] exp_a(input logic [1:0] id);
        return (16'h3000 + {14'd0, id}) ^ 16'hFFFF;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_operands;
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*IB +: IB] = 16'h1000 + 16'h0111 * 16'(i);
            req_y[i*IB +: IB] = 16'h2000 + 16'(i);
            req_a[i*IB +: IB] = 16'h3000 + 16'(i);
        end
    endtask

    task automatic reset_pulse;
        nGrst = 1'b0;
        tick();
        nGrst = 1'b1;
    endtask

    task automatic test_reset;
        nGrst = 1'b0; req_valid = 4'hF; res_ready = 1'b0; spur = 1'b0;
        set_operands();
        repeat (LAT + 2) tick();
        vecs++; if (req_ready !== 4'h0) begin errs++; $display("FAIL reset_req_ready got=%h exp=0", req_ready); end
        vecs++; if (cor_din_valid !== 1'b0) begin errs++; $display("FAIL reset_din_valid got=%b exp=0", cor_din_valid); end
        vecs++; if ({cor_din_x, cor_din_y, cor_din_a} !== 48'h0) begin errs++; $display("FAIL reset_din_data got=%h exp=0", {cor_din_x, cor_din_y, cor_din_a}); end
        vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        vecs++; if (res_id !== 2'd0) begin errs++; $display("FAIL reset_res_id got=%0d exp=0", res_id); end
        vecs++; if ({res_x, res_y, res_a} !== 48'h0) begin errs++; $display("FAIL reset_res_data got=%h exp=0", {res_x, res_y, res_a}); end
        vecs++; if (tag_err !== 1'b0) begin errs++; $display("FAIL reset_tag_err got=%b exp=0", tag_err); end
        nGrst = 1'b1; req_valid = 4'h0;
        tick();
    endtask

    task automatic test_single;
        int lat;
        req_x[2*IB +: IB] = 16'h4000; req_y[2*IB +: IB] = 16'h0000; req_a[2*IB +: IB] = 16'h2000;
        res_ready = 1'b0;
        req_valid = 4'b0100;
        #1;
        vecs++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        tick();
        req_valid = 4'h0;
        vecs++; if (cor_din_valid !== 1'b1) begin errs++; $display("FAIL single_din_valid got=%b exp=1", cor_din_valid); end
        vecs++; if ({cor_din_x, cor_din_y, cor_din_a} !== {16'h4000, 16'h0000, 16'h2000}) begin
            errs++; $display("FAIL single_din_data got=%h exp=400000002000", {cor_din_x, cor_din_y, cor_din_a}); end
        lat = 0;
        for (int n = 2; n <= 40; n++) begin
            tick();
            if (res_valid === 1'b1 && lat == 0) lat = n;
        end
        vecs++; if (lat != LAT + 2) begin errs++; $display("FAIL single_latency got=%0d exp=%0d", lat, LAT + 2); end
        vecs++; if (res_id !== 2'd2) begin errs++; $display("FAIL single_res_id got=%0d exp=2", res_id); end
        vecs++; if ({res_x, res_y, res_a} !== {16'h4001, 16'h0000, 16'hDFFF}) begin
            errs++; $display("FAIL single_res_data got=%h exp=40010000dfff", {res_x, res_y, res_a}); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL single_pop got=%b exp=0", res_valid); end
        set_operands();
    endtask

    // Fairness and full-rate streaming: from cycle 30 on, every cycle pops, writes and grants.
    task automatic test_round_robin;
        logic [3:0] exp_rdy;
        logic [1:0] id_e;
        int got;
        exp_q.delete();
        reset_pulse();
        res_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 100; c++) begin
            req_valid = (c < 40) ? 4'hF : 4'h0;
            #1;
            if (c < 40) begin
                exp_rdy = 4'(1 << (c % 4));
                vecs++; if (req_ready !== exp_rdy) begin errs++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
                exp_q.push_back(2'(c % 4));
            end
            if (c >= 1 && c <= 40) begin
                vecs++; if (cor_din_valid !== 1'b1) begin errs++; $display("FAIL rr_issue c=%0d got=%b exp=1", c, cor_din_valid); end
            end
            if (res_valid === 1'b1) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL rr_extra_result c=%0d id=%0d", c, res_id);
                end else begin
                    id_e = exp_q.pop_front();
                    if (res_id !== id_e || res_x !== exp_x(id_e) || res_y !== exp_y(id_e) || res_a !== exp_a(id_e)) begin
                        errs++; $display("FAIL rr_result c=%0d got id=%0d x=%h y=%h a=%h exp id=%0d x=%h y=%h a=%h",
                                         c, res_id, res_x, res_y, res_a, id_e, exp_x(id_e), exp_y(id_e), exp_a(id_e));
                    end
                end
                got++;
            end
            tick();
        end
        vecs++; if (got != 40 || exp_q.size() != 0) begin errs++; $display("FAIL rr_count got=%0d exp=40 left=%0d", got, exp_q.size()); end
    endtask

    task automatic test_backpressure;
        int grants, got;
        logic [1:0] id_e;
        exp_q.delete();
        reset_pulse();
        res_ready = 1'b0;
        req_valid = 4'hF;
        grants = 0;
        for (int c = 0; c < 70; c++) begin
            #1;
            if (req_ready !== 4'h0) begin
                exp_q.push_back(2'(grants % 4));
                grants++;
            end
            tick();
        end
        vecs++; if (grants != DEPTH) begin errs++; $display("FAIL bp_grants got=%0d exp=%0d", grants, DEPTH); end
        vecs++; if (req_ready !== 4'h0) begin errs++; $display("FAIL bp_stall got=%b exp=0000", req_ready); end
        vecs++; if (res_valid !== 1'b1) begin errs++; $display("FAIL bp_res_valid got=%b exp=1", res_valid); end
        res_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 100; c++) begin
            req_valid = (c < 3) ? 4'hF : 4'h0;
            #1;
            if (c == 0) begin
                vecs++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL bp_resume0 got=%b exp=0000", req_ready); end
            end
            if (c == 1) begin
                vecs++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL bp_resume1 got=%b exp=0001", req_ready); end
            end
            if (c == 2) begin
                vecs++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL bp_resume2 got=%b exp=0010", req_ready); end
            end
            if (c == 1 || c == 2) exp_q.push_back(2'(c - 1));
            if (res_valid === 1'b1) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL bp_extra_result c=%0d id=%0d", c, res_id);
                end else begin
                    id_e = exp_q.pop_front();
                    if (res_id !== id_e || res_x !== exp_x(id_e) || res_y !== exp_y(id_e)) begin
                        errs++; $display("FAIL bp_result c=%0d got id=%0d x=%h y=%h exp id=%0d x=%h y=%h",
                                         c, res_id, res_x, res_y, id_e, exp_x(id_e), exp_y(id_e));
                    end
                end
                got++;
            end
            tick();
        end
        vecs++; if (got != DEPTH + 2) begin errs++; $display("FAIL bp_drain_count got=%0d exp=%0d", got, DEPTH + 2); end
    endtask

    task automatic test_spurious;
        res_ready = 1'b0;
        req_valid = 4'h0;
        spur = 1'b1;
        tick();
        spur = 1'b0;
        vecs++; if (tag_err !== TAG_EXP) begin errs++; $display("FAIL spur_tag_err got=%b exp=%b", tag_err, TAG_EXP); end
        vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL spur_fifo got=%b exp=0", res_valid); end
        repeat (100) tick();
        vecs++; if (tag_err !== TAG_EXP) begin errs++; $display("FAIL spur_sticky got=%b exp=%b", tag_err, TAG_EXP); end
        vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL spur_fifo_late got=%b exp=0", res_valid); end
    endtask

    task automatic test_reset_mid;
        int seen;
        res_ready = 1'b1;
        req_valid = 4'hF;
        repeat (10) tick();
        req_valid = 4'h0;
        nGrst = 1'b0;
        #1;
        vecs++; if (req_ready !== 4'h0) begin errs++; $display("FAIL mid_req_ready got=%b exp=0000", req_ready); end
        tick();
        vecs++; if (cor_din_valid !== 1'b0) begin errs++; $display("FAIL mid_din_valid got=%b exp=0", cor_din_valid); end
        vecs++; if ({cor_din_x, cor_din_y, cor_din_a} !== 48'h0) begin errs++; $display("FAIL mid_din_data got=%h exp=0", {cor_din_x, cor_din_y, cor_din_a}); end
        vecs++; if ({res_valid, res_id, res_x, res_y, res_a} !== 51'h0) begin errs++; $display("FAIL mid_res got=%h exp=0", {res_valid, res_id, res_x, res_y, res_a}); end
        vecs++; if (tag_err !== 1'b0) begin errs++; $display("FAIL mid_tag_err got=%b exp=0", tag_err); end
        nGrst = 1'b1;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (res_valid !== 1'b0) seen++;
        end
        vecs++; if (seen != 0) begin errs++; $display("FAIL mid_leak got=%0d cycles exp=0", seen); end
        vecs++; if (tag_err !== TAG_EXP) begin errs++; $display("FAIL mid_leftover_tag_err got=%b exp=%b", tag_err, TAG_EXP); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
